// File: rtl/serial_tx_frame.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional
// even parity, stop bit, each held for BIT_CYCLES clocks.
module serial_tx_frame #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             busy,
  output logic             tx,
  output logic             done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shift;
  logic [BW-1:0]    bitcnt;
  logic [CW-1:0]    cyc;
  logic             par;
  logic             bit_end;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  assign shreg_shift = shreg >> 1;
  assign bit_end     = (cyc == CW'(BIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      cyc    <= '0;
      par    <= 1'b0;
      tx     <= 1'b1;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      // Every non-idle state shares the same per-bit cycle counter.
      if (state != IDLE)
        cyc <= bit_end ? '0 : cyc + CW'(1);
      case (state)
        IDLE: begin
          if (load) begin
            shreg  <= data;
            par    <= even_parity(data);
            bitcnt <= '0;
            cyc    <= '0;
            tx     <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bitcnt == BW'(WIDTH - 1)) begin
              bitcnt <= '0;
              tx     <= (PARITY_EN != 0) ? par : 1'b1;
              state  <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              shreg  <= shreg_shift;
              tx     <= shreg_shift[0];
              bitcnt <= bitcnt + BW'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            tx    <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
